axi_burst_master: RTL
=====================

// Module: axi_burst_master
// PURPOSE
//  AXI4 burst initiator: the manager end of the AW/W/B/AR/R bus presented by the team's AXI memory slave.
//  Takes one command (read/write, addr, len, size) on a valid/ready port, runs one complete burst, then
//  reports completion with the worst response seen. One transaction outstanding; INCR bursts only.
//  Write data streams in and read data streams out on valid/ready ports.
// PARAMETERS
//  DATA_WIDTH  32  data bus width in bits; power of 2, 8..1024
//  ADDR_WIDTH  16  byte address width
// PORTS
//  ACLK        in   1           clock; all logic rising-edge
//  ARESETn     in   1           asynchronous active-low reset
//  cmd_valid   in   1           command request
//  cmd_ready   out  1           high only in IDLE
//  cmd_write   in   1           1 = write burst, 0 = read burst
//  cmd_addr    in   ADDR_WIDTH  start byte address
//  cmd_len     in   8           beats-1 (AXI LEN encoding)
//  cmd_size    in   3           log2(bytes per beat)
//  wr_data     in   DATA_WIDTH  write stream data
//  wr_valid    in   1           write stream valid
//  wr_ready    out  1           = WREADY while in W_DATA, else 0
//  rd_data     out  DATA_WIDTH  read stream data (= RDATA)
//  rd_valid    out  1           = RVALID while in R_DATA
//  rd_last     out  1           = RLAST while in R_DATA
//  rd_ready    in   1           read stream ready; drives RREADY in R_DATA
//  done        out  1           one-cycle completion pulse
//  done_resp   out  2           worst response of the finished burst, valid with done
//  AW*: AWADDR/AWLEN/AWSIZE/AWVALID out, AWREADY in; W*: WDATA/WLAST/WVALID out, WREADY in
//  B*: BRESP/BVALID in, BREADY out; AR*: ARADDR/ARLEN/ARSIZE/ARVALID out, ARREADY in
//  R*: RDATA/RRESP/RLAST/RVALID in, RREADY out; widths as AXI4 (LEN 8, SIZE 3, RESP 2)
// BEHAVIOUR
//  Reset: state IDLE; all VALID/READY outputs, done, rd_valid, rd_last 0. done_resp, addr/len/size regs 0.
//  Async reset mid-burst drops every VALID immediately; the burst is abandoned and done is not pulsed.
//  FSM: IDLE -> (cmd_valid, write) AW_ADDR -> W_DATA -> B_RESP -> IDLE.
//  FSM: IDLE -> (cmd_valid, read) AR_ADDR -> R_DATA -> IDLE.
//  Command capture: cmd_valid&&cmd_ready registers addr/len/size. If cmd_size > log2(DATA_WIDTH/8), go
//   straight to DONE handling: done=1, done_resp=2'b10 the next cycle, no bus activity.
//  AW_ADDR/AR_ADDR: VALID asserted the cycle after capture, held with stable payload until READY; then advance.
//  W_DATA: WVALID=wr_valid, WDATA=wr_data, wr_ready=WREADY. 8-bit beat counter from 0; WLAST=(cnt==len).
//   Beat on WVALID&&WREADY increments cnt; beat with WLAST -> B_RESP. No W before the AW handshake completes.
//  B_RESP: BREADY=1; on BVALID latch BRESP, pulse done, return to IDLE.
//  R_DATA: RREADY=rd_ready; each RVALID&&RREADY beat increments cnt; resp accumulator keeps max(RRESP).
//   On the RLAST beat: done pulses next cycle. Protocol check: RLAST on beat cnt!=len, or no RLAST at
//   cnt==len -> done_resp forced to 2'b10 (SLVERR). Burst always terminates on RLAST.
//  done_resp = max response (DECERR 3 > SLVERR 2 > EXOKAY 1 > OKAY 0) across the burst.
//  Latency: cmd accept -> AWVALID/ARVALID 1 cycle; last handshake -> done 1 cycle; cmd_ready high again
//   in the done cycle (back-to-back commands accepted).
//  AWADDR/ARADDR pass through unaligned and unchecked; the 4 KB boundary is the caller's responsibility.
//  len=0: single beat, WLAST high on first beat. len=255: counter reaches 255 without wrap.
// STRUCTURE
//  axi_pkg: typedef enum resp_t {OKAY, EXOKAY, SLVERR, DECERR}; typedef enum state_t of FSM states;
//   localparam BURST_INCR=2'b01. Shared with the slave and benches.
//  Single module, no sub-modules; one FSM, one beat counter, one resp accumulator.
// TESTING
//  1 Write len=3 size=2 addr=0x0040, slave always ready -> AWLEN=3, 4 W beats, WLAST on 4th, done resp=0.
//  2 Read len=7 addr=0x0100 with rd_ready toggling 1/0 -> 8 beats in order, no beat lost, rd_last on 8th.
//  3 Read len=3, slave returns RRESP 0,2,0,3 -> done_resp=3; write with BRESP=2 -> done_resp=2.
//  4 Read len=3, slave raises RLAST on beat 2 -> burst ends, done_resp=2.
//  5 cmd_size=3 with DATA_WIDTH=32 -> no AWVALID/ARVALID ever, done next cycle, done_resp=2.
//  6 ARESETn low during W beat 2 of len=7 -> WVALID/AWVALID 0 same cycle, IDLE; new command runs cleanly.

Source files
------------

// File: rtl/axi_pkg.sv
//----------------------------------------------------------------------------
// axi_pkg : AXI4 response and FSM state types shared by master, slave, benches
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    AW_ADDR = 3'd1,
    W_DATA  = 3'd2,
    B_RESP  = 3'd3,
    AR_ADDR = 3'd4,
    R_DATA  = 3'd5
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Response severity follows the encoding order, so the worst is the numeric max.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_master.sv
//----------------------------------------------------------------------------
// axi_burst_master : single-outstanding AXI4 INCR burst initiator with streams
// Rev 1.0
//----------------------------------------------------------------------------
`default_nettype none

module axi_burst_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic [7:0]            AWLEN,
  output logic [2:0]            AWSIZE,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WLAST,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic [7:0]            ARLEN,
  output logic [2:0]            ARSIZE,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RLAST,
  input  logic                  RVALID,
  output logic                  RREADY
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_WIDTH / 8));

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            acc_q, acc_d;
  logic                  perr_q, perr_d;
  logic                  done_q, done_d;
  logic [1:0]            done_resp_q, done_resp_d;
  logic                  beat_err;
  logic [1:0]            beat_resp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      perr_q      <= 1'b0;
      done_q      <= 1'b0;
      done_resp_q <= '0;
    end else begin
      addr_q      <= addr_d;
      len_q       <= len_d;
      size_q      <= size_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      perr_q      <= perr_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    size_d      = size_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    perr_d      = perr_q;
    done_d      = 1'b0;
    done_resp_d = done_resp_q;
    beat_resp   = resp_max(acc_q, RRESP);
    beat_err    = RLAST ^ (cnt_q == len_q);
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          size_d = cmd_size;
          cnt_d  = '0;
          acc_d  = OKAY;
          perr_d = 1'b0;
          // Oversized beats are refused without touching the bus.
          if (cmd_size > SIZE_MAX) begin
            done_d      = 1'b1;
            done_resp_d = SLVERR;
          end else if (cmd_write) begin
            state_d = AW_ADDR;
          end else begin
            state_d = AR_ADDR;
          end
        end
      end
      AW_ADDR: if (AWREADY) state_d = W_DATA;
      W_DATA: begin
        if (wr_valid && WREADY) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = B_RESP;
        end
      end
      B_RESP: begin
        if (BVALID) begin
          done_d      = 1'b1;
          done_resp_d = resp_max(acc_q, BRESP);
          state_d     = IDLE;
        end
      end
      AR_ADDR: if (ARREADY) state_d = R_DATA;
      R_DATA: begin
        if (RVALID && rd_ready) begin
          cnt_d  = cnt_q + 8'd1;
          acc_d  = beat_resp;
          perr_d = perr_q | beat_err;
          // RLAST always ends the burst; a misplaced or missing RLAST flags SLVERR.
          if (RLAST) begin
            done_d      = 1'b1;
            state_d     = IDLE;
            done_resp_d = (perr_q | beat_err) ? resp_max(beat_resp, SLVERR) : beat_resp;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    AWADDR    = addr_q;
    AWLEN     = len_q;
    AWSIZE    = size_q;
    AWVALID   = (state_q == AW_ADDR);
    ARADDR    = addr_q;
    ARLEN     = len_q;
    ARSIZE    = size_q;
    ARVALID   = (state_q == AR_ADDR);
    WDATA     = wr_data;
    WVALID    = 1'b0;
    WLAST     = 1'b0;
    wr_ready  = 1'b0;
    BREADY    = 1'b0;
    RREADY    = 1'b0;
    rd_data   = RDATA;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = done_q;
    done_resp = done_resp_q;
    case (state_q)
      W_DATA: begin
        WVALID   = wr_valid;
        WLAST    = (cnt_q == len_q);
        wr_ready = WREADY;
      end
      B_RESP: BREADY = 1'b1;
      R_DATA: begin
        RREADY   = rd_ready;
        rd_valid = RVALID;
        rd_last  = RLAST;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire
